mbisr_repair_mem: RTL and testbench
===================================

Name: mbisr_repair_mem

Overview:
- Memory-side responder for the MBIST engine: 2^ADDR_W x DATA_W main array plus NUM_SPARES fault-free spare words with a repair CAM.
- Serves the BIST write/read bus, captures each reported failing address into a spare, and redirects later accesses to that address into the spare.
- Includes a single stuck-at fault injector so the BIST/BISR loop can be exercised in simulation and on silicon.

Parameters:
ADDR_W, 8, address width; main array depth 2^ADDR_W
DATA_W, 8, word width
NUM_SPARES, 4, number of spare words (1..8)

Ports:
clk  in  1  clock
rst  in  1  reset, synchronous, active-high
mem_we  in  1  write strobe, sampled at rising edge
mem_addr  in  ADDR_W  access address
mem_wdata  in  DATA_W  write data
mem_rdata  out  DATA_W  read data, combinational from mem_addr
fail_valid  in  1  one-cycle pulse: fail_addr is faulty
fail_addr  in  ADDR_W  failing address
bist_done  in  1  level, BIST finished
repair_en  in  1  1 = allocate spares and redirect; 0 = raw array
inj_load  in  1  pulse: capture fault config
inj_addr  in  ADDR_W  faulty address
inj_bit  in  $clog2(DATA_W)  faulty bit index
inj_val  in  1  stuck-at value
spares_used  out  $clog2(NUM_SPARES+1)  allocated spare count
repair_fail  out  1  sticky: fail reported with no spare left
repair_ok  out  1  bist_done && !repair_fail, registered

Behaviour:
- Reset (synchronous, active-high): clears spares_used, repair_fail, repair_ok, all CAM valid bits, and fault_active. Main array and spare data are not reset. mem_rdata follows its combinational path.
- Lookup: hit = repair_en && some valid CAM entry k has tag == mem_addr. Tags are unique, so at most one entry hits.
- Write: on a rising edge with mem_we=1:
  - hit -> spare[k] <= mem_wdata.
  - no hit -> main[mem_addr] <= mem_wdata.
  - The injector never alters stored data.
- Read, zero latency:
  - hit -> mem_rdata = spare[k].
  - no hit -> mem_rdata = main[mem_addr], with bit inj_bit forced to inj_val when fault_active and mem_addr == fault address.
  - A write is visible on the next cycle's read.
- Allocation: on a rising edge with fail_valid=1 and repair_en=1:
  - fail_addr already tagged -> no change.
  - spares_used < NUM_SPARES -> entry[spares_used] <= {valid, fail_addr}, spare data <= 0, spares_used += 1.
  - otherwise -> repair_fail <= 1. It stays set until rst; spares_used saturates at NUM_SPARES.
- Simultaneous allocation and write to the same address on one edge: the new spare takes mem_wdata, not 0. The main array is not written.
- fail_valid with repair_en=0: ignored entirely, including repair_fail.
- Injector: inj_load captures inj_addr/inj_bit/inj_val and sets fault_active. A later inj_load overwrites the config; only one fault is active at a time.
- repair_ok: registered each cycle as bist_done && !repair_fail. It drops the cycle after repair_fail rises.
- Controller timing to meet: address/write registered, one cycle for the write, compare on the following cycle against mem_rdata. Combinational read satisfies this.
- Reset mid-run: takes effect on the next edge; the repair table is lost and the BIST must be rerun.

Test Plan:
- No fault, repair_en=1, full write-0/read sweep 0x00..0xFF -> every read 0x00, spares_used=0, repair_fail=0, repair_ok=1 one cycle after bist_done.
- inj_load addr 0x3C bit 2 val 1; write 0x00 to 0x3C -> read 0x04. Then fail_valid/fail_addr=0x3C -> spares_used=1. Write 0x00, read 0x3C -> 0x00. Read 0x3D -> unaffected.
- fail_valid 0x3C on two separate cycles -> spares_used stays 1, repair_fail=0.
- Distinct fails 0x10,0x20,0x30,0x40,0x50 -> spares_used=4 after fourth, repair_fail=1 after fifth. With bist_done=1 -> repair_ok=0. Reads of 0x10..0x40 come from spares.
- repair_en=0, fault at 0x3C stuck-1 bit 2, fail_valid 0x3C -> spares_used=0, read 0x3C still 0x04.
- Same-edge fail_valid 0x77 with mem_we to 0x77 data 0xA5 -> next read 0x77 = 0xA5 from spare. Then rst one cycle -> spares_used=0, fault_active=0, read 0x3C returns stored main-array value with no bit forced.

Source files
------------

// File: rtl/mbisr_repair_mem_if.sv
// BIST-to-memory bus: access port, fail reporting, repair control and fault injector.
// The master side is the BIST controller; the slave side is the repairable memory.
interface mbisr_repair_mem_if #(
    parameter int ADDR_W     = 8,
    parameter int DATA_W     = 8,
    parameter int NUM_SPARES = 4
);
    localparam int IDX_W = (DATA_W > 1) ? $clog2(DATA_W) : 1;
    localparam int CNT_W = $clog2(NUM_SPARES + 1);

    logic              mem_we;
    logic [ADDR_W-1:0] mem_addr;
    logic [DATA_W-1:0] mem_wdata;
    logic [DATA_W-1:0] mem_rdata;
    logic              fail_valid;
    logic [ADDR_W-1:0] fail_addr;
    logic              bist_done;
    logic              repair_en;
    logic              inj_load;
    logic [ADDR_W-1:0] inj_addr;
    logic [IDX_W-1:0]  inj_bit;
    logic              inj_val;
    logic [CNT_W-1:0]  spares_used;
    logic              repair_fail;
    logic              repair_ok;

    modport master (
        output mem_we, mem_addr, mem_wdata, fail_valid, fail_addr, bist_done,
               repair_en, inj_load, inj_addr, inj_bit, inj_val,
        input  mem_rdata, spares_used, repair_fail, repair_ok
    );

    modport slave (
        input  mem_we, mem_addr, mem_wdata, fail_valid, fail_addr, bist_done,
               repair_en, inj_load, inj_addr, inj_bit, inj_val,
        output mem_rdata, spares_used, repair_fail, repair_ok
    );
endinterface

// File: rtl/mbisr_repair_mem.sv
// Repairable memory for MBIST/BISR: main array, spare words behind a repair CAM,
// and a single stuck-at fault injector on the main-array read path.
module mbisr_repair_mem #(
    parameter int ADDR_W     = 8,
    parameter int DATA_W     = 8,
    parameter int NUM_SPARES = 4
) (
    input logic                  clk,
    input logic                  rst,
    mbisr_repair_mem_if.slave    bus
);
    localparam int IDX_W  = (DATA_W > 1) ? $clog2(DATA_W) : 1;
    localparam int CNT_W  = $clog2(NUM_SPARES + 1);
    localparam int SIDX_W = (NUM_SPARES > 1) ? $clog2(NUM_SPARES) : 1;
    localparam logic [CNT_W-1:0] MAX_CNT = CNT_W'(NUM_SPARES);

    logic [DATA_W-1:0] main_mem  [2**ADDR_W];
    logic [DATA_W-1:0] spare_mem [NUM_SPARES];
    logic [ADDR_W-1:0] tag_mem   [NUM_SPARES];
    logic [NUM_SPARES-1:0] cam_vld;

    logic [CNT_W-1:0]  spares_cnt;
    logic              repair_fail_q;
    logic              repair_ok_q;

    logic              fault_active;
    logic [ADDR_W-1:0] fault_addr;
    logic [IDX_W-1:0]  fault_bit;
    logic              fault_val;

    logic              hit_raw;
    logic              hit;
    logic [SIDX_W-1:0] hit_idx;
    logic              fail_tagged;
    logic              alloc;
    logic              alloc_same_wr;
    logic [SIDX_W-1:0] alloc_idx;
    logic [DATA_W-1:0] main_rd;

    // CAM lookups for the access address and the reported failing address
    always_comb begin
        hit_raw     = 1'b0;
        hit_idx     = '0;
        fail_tagged = 1'b0;
        for (int k = 0; k < NUM_SPARES; k++) begin
            if (cam_vld[k] && tag_mem[k] == bus.mem_addr) begin
                hit_raw = 1'b1;
                hit_idx = SIDX_W'(k);
            end
            if (cam_vld[k] && tag_mem[k] == bus.fail_addr) begin
                fail_tagged = 1'b1;
            end
        end
    end

    assign hit           = bus.repair_en && hit_raw;
    assign alloc         = bus.fail_valid && bus.repair_en && !fail_tagged && (spares_cnt < MAX_CNT);
    assign alloc_same_wr = alloc && bus.mem_we && (bus.mem_addr == bus.fail_addr);
    assign alloc_idx     = SIDX_W'(spares_cnt);

    // Fault forcing only ever touches the main-array read path, never stored data
    always_comb begin
        main_rd = main_mem[bus.mem_addr];
        if (fault_active && bus.mem_addr == fault_addr) begin
            main_rd[fault_bit] = fault_val;
        end
    end

    assign bus.mem_rdata   = hit ? spare_mem[hit_idx] : main_rd;
    assign bus.spares_used = spares_cnt;
    assign bus.repair_fail = repair_fail_q;
    assign bus.repair_ok   = repair_ok_q;

    // Data storage: arrays, tags and fault config carry no reset
    always_ff @(posedge clk) begin
        if (bus.mem_we) begin
            if (hit) begin
                spare_mem[hit_idx] <= bus.mem_wdata;
            end else if (!alloc_same_wr) begin
                main_mem[bus.mem_addr] <= bus.mem_wdata;
            end
        end
        if (alloc) begin
            tag_mem[alloc_idx]   <= bus.fail_addr;
            spare_mem[alloc_idx] <= alloc_same_wr ? bus.mem_wdata : '0;
        end
        if (bus.inj_load) begin
            fault_addr <= bus.inj_addr;
            fault_bit  <= bus.inj_bit;
            fault_val  <= bus.inj_val;
        end
    end

    // Control state: repair table occupancy, status flags, injector enable
    always_ff @(posedge clk) begin
        if (rst) begin
            spares_cnt    <= '0;
            repair_fail_q <= 1'b0;
            repair_ok_q   <= 1'b0;
            cam_vld       <= '0;
            fault_active  <= 1'b0;
        end else begin
            if (bus.inj_load) begin
                fault_active <= 1'b1;
            end
            if (alloc) begin
                cam_vld[alloc_idx] <= 1'b1;
                spares_cnt         <= spares_cnt + CNT_W'(1);
            end else if (bus.fail_valid && bus.repair_en && !fail_tagged) begin
                repair_fail_q <= 1'b1;
            end
            repair_ok_q <= bus.bist_done && !repair_fail_q;
        end
    end
endmodule

// File: tb/tb_mbisr_repair_mem.sv
// Directed-plus-random bench for mbisr_repair_mem against an address-keyed reference model.
module tb_mbisr_repair_mem;
    localparam int AW = 8;
    localparam int DW = 8;
    localparam int NS = 4;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    mbisr_repair_mem_if #(.ADDR_W(AW), .DATA_W(DW), .NUM_SPARES(NS)) bus ();

    mbisr_repair_mem #(.ADDR_W(AW), .DATA_W(DW), .NUM_SPARES(NS)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    int checks = 0;
    int errors = 0;

    // Reference model: spares are a map from repaired address to data
    logic [DW-1:0] main_m [2**AW];
    logic [DW-1:0] spare_m [logic [AW-1:0]];
    int            used_m  = 0;
    bit            rfail_m = 0;
    bit            rok_m   = 0;
    bit            fact_m  = 0;
    logic [AW-1:0] faddr_m = '0;
    logic [2:0]    fbit_m  = '0;
    bit            fval_m  = 0;
    bit            hit_pre, new_ok, fail_new, rfail_old;

    always @(posedge clk) begin
        if (rst) begin
            spare_m.delete();
            used_m  = 0;
            rfail_m = 0;
            rok_m   = 0;
            fact_m  = 0;
        end else begin
            rfail_old = rfail_m;
            hit_pre   = bus.repair_en && spare_m.exists(bus.mem_addr);
            fail_new  = bus.fail_valid && bus.repair_en && !spare_m.exists(bus.fail_addr);
            new_ok    = fail_new && (used_m < NS);
            if (bus.mem_we) begin
                if (hit_pre) spare_m[bus.mem_addr] = bus.mem_wdata;
                else if (!(new_ok && bus.fail_addr == bus.mem_addr)) main_m[bus.mem_addr] = bus.mem_wdata;
            end
            if (new_ok) begin
                spare_m[bus.fail_addr] = (bus.mem_we && bus.mem_addr == bus.fail_addr) ? bus.mem_wdata : '0;
                used_m++;
            end else if (fail_new) begin
                rfail_m = 1;
            end
            if (bus.inj_load) begin
                fact_m  = 1;
                faddr_m = bus.inj_addr;
                fbit_m  = bus.inj_bit;
                fval_m  = bus.inj_val;
            end
            rok_m = bus.bist_done && !rfail_old;
        end
    end

    function automatic logic [DW-1:0] model_read(logic [AW-1:0] a);
        logic [DW-1:0] v;
        if (bus.repair_en && spare_m.exists(a)) return spare_m[a];
        v = main_m[a];
        if (fact_m && a == faddr_m) v[fbit_m] = fval_m;
        return v;
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Inputs change only at the falling edge; single-cycle pulses are cleared afterwards
    task automatic cyc();
        @(posedge clk);
        @(negedge clk);
        bus.mem_we     = 1'b0;
        bus.fail_valid = 1'b0;
        bus.inj_load   = 1'b0;
    endtask

    task automatic wr(input logic [AW-1:0] a, input logic [DW-1:0] d);
        bus.mem_we    = 1'b1;
        bus.mem_addr  = a;
        bus.mem_wdata = d;
        cyc();
    endtask

    task automatic fail(input logic [AW-1:0] a);
        bus.fail_valid = 1'b1;
        bus.fail_addr  = a;
        cyc();
    endtask

    task automatic inject(input logic [AW-1:0] a, input logic [2:0] b, input logic v);
        bus.inj_load = 1'b1;
        bus.inj_addr = a;
        bus.inj_bit  = b;
        bus.inj_val  = v;
        cyc();
    endtask

    task automatic rd_chk(input string tag, input logic [AW-1:0] a);
        bus.mem_addr = a;
        #1;
        chk(tag, 32'(bus.mem_rdata), 32'(model_read(a)));
    endtask

    task automatic status_chk(input string tag);
        chk({tag, "_used"}, 32'(bus.spares_used), 32'(used_m));
        chk({tag, "_rfail"}, 32'(bus.repair_fail), 32'(rfail_m));
        chk({tag, "_rok"}, 32'(bus.repair_ok), 32'(rok_m));
    endtask

    task automatic do_reset();
        rst = 1'b1;
        cyc();
        rst = 1'b0;
    endtask

    initial begin
        bus.mem_we = 0; bus.mem_addr = '0; bus.mem_wdata = '0;
        bus.fail_valid = 0; bus.fail_addr = '0; bus.bist_done = 0;
        bus.repair_en = 1; bus.inj_load = 0; bus.inj_addr = '0;
        bus.inj_bit = '0; bus.inj_val = 0;
        foreach (main_m[i]) main_m[i] = '0;

        @(negedge clk);
        cyc();
        rst = 1'b0;
        chk("reset_used", 32'(bus.spares_used), 32'd0);
        chk("reset_rfail", 32'(bus.repair_fail), 32'd0);
        chk("reset_rok", 32'(bus.repair_ok), 32'd0);

        // Fault-free write-0/read sweep
        for (int a = 0; a < 256; a++) wr(AW'(a), '0);
        for (int a = 0; a < 256; a++) begin
            bus.mem_addr = AW'(a);
            #1;
            chk("sweep_rd", 32'(bus.mem_rdata), 32'd0);
        end
        bus.bist_done = 1'b1;
        cyc();
        chk("sweep_rok", 32'(bus.repair_ok), 32'd1);
        status_chk("sweep");
        bus.bist_done = 1'b0;

        // Stuck-at-1 on bit 2 of 0x3C, then repair it
        inject(8'h3C, 3'd2, 1'b1);
        wr(8'h3C, 8'h00);
        bus.mem_addr = 8'h3C;
        #1;
        chk("inj_rd", 32'(bus.mem_rdata), 32'h04);
        fail(8'h3C);
        chk("rep_used", 32'(bus.spares_used), 32'd1);
        wr(8'h3C, 8'h00);
        bus.mem_addr = 8'h3C;
        #1;
        chk("rep_rd", 32'(bus.mem_rdata), 32'h00);
        rd_chk("nbr_rd", 8'h3D);

        // Duplicate fail reports consume nothing
        fail(8'h3C);
        cyc();
        fail(8'h3C);
        status_chk("dup");

        // Random traffic including the repaired address
        for (int i = 0; i < 300; i++) begin
            logic [AW-1:0] a;
            a = ($urandom_range(0, 3) == 0) ? 8'h3C : AW'($urandom);
            if ($urandom_range(0, 1) == 1) wr(a, DW'($urandom));
            rd_chk("rand_rd", a);
        end
        status_chk("rand");

        // Exhaust the spares
        do_reset();
        status_chk("rst2");
        fail(8'h10); fail(8'h20); fail(8'h30); fail(8'h40);
        chk("full_used", 32'(bus.spares_used), 32'd4);
        chk("full_rfail", 32'(bus.repair_fail), 32'd0);
        fail(8'h50);
        chk("over_rfail", 32'(bus.repair_fail), 32'd1);
        fail(8'h60);
        chk("sat_used", 32'(bus.spares_used), 32'd4);
        bus.bist_done = 1'b1;
        cyc();
        chk("over_rok", 32'(bus.repair_ok), 32'd0);
        status_chk("over");
        bus.bist_done = 1'b0;
        for (int k = 1; k <= 5; k++) wr(AW'(k * 16), DW'($urandom));
        for (int k = 1; k <= 5; k++) begin
            rd_chk("spare_rd", AW'(k * 16));
            bus.mem_addr = AW'(k * 16);
            #1;
            if (k < 5) chk("spare_src", 32'(bus.mem_rdata), 32'(spare_m[AW'(k * 16)]));
        end
        bus.repair_en = 1'b0;
        for (int k = 1; k <= 5; k++) rd_chk("raw_rd", AW'(k * 16));

        // Repair disabled: fail reports are ignored, fault stays visible
        do_reset();
        inject(8'h3C, 3'd2, 1'b1);
        wr(8'h3C, 8'h00);
        fail(8'h3C);
        chk("dis_used", 32'(bus.spares_used), 32'd0);
        chk("dis_rfail", 32'(bus.repair_fail), 32'd0);
        bus.mem_addr = 8'h3C;
        #1;
        chk("dis_rd", 32'(bus.mem_rdata), 32'h04);

        // Allocation and write to the same address on one edge
        bus.repair_en  = 1'b1;
        bus.mem_we     = 1'b1;
        bus.mem_addr   = 8'h77;
        bus.mem_wdata  = 8'hA5;
        bus.fail_valid = 1'b1;
        bus.fail_addr  = 8'h77;
        cyc();
        bus.mem_addr = 8'h77;
        #1;
        chk("same_rd", 32'(bus.mem_rdata), 32'hA5);
        bus.repair_en = 1'b0;
        rd_chk("same_main", 8'h77);
        bus.repair_en = 1'b1;

        // Reset drops repairs and the injected fault
        do_reset();
        status_chk("rst3");
        bus.mem_addr = 8'h3C;
        #1;
        chk("rst_rd", 32'(bus.mem_rdata), 32'h00);
        rd_chk("rst_rd77", 8'h77);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
